// File: rtl/qr_recon_pkg.sv
// Shared widths, FSM encoding and output scaling for the QR reconstruction block.
// Build option: define QR_RECON_ROUND_EN for round-half-up instead of floor.
package qr_recon_pkg;

    localparam int R_W    = 12;
    localparam int Q_W    = 12;
    localparam int A_W    = 8;
    localparam int R_FRAC = 3;
    localparam int Q_FRAC = 10;
    localparam int PROD_W = 24;
    localparam int ACC_W  = 26;
    localparam int N      = 4;

    localparam int SHIFT = R_FRAC + Q_FRAC;

    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] A_MAX = ACC_W'((1 << (A_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] A_MIN = -A_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CAL,
        S_OUTPUT
    } state_t;

    function automatic logic signed [A_W-1:0] sat_scale(
        input logic signed [ACC_W-1:0] s
    );
        logic signed [ACC_W-1:0] v;
`ifdef QR_RECON_ROUND_EN
        v = (s + RND) >>> SHIFT;
`else
        v = s >>> SHIFT;
`endif
        if (v > A_MAX)
            v = A_MAX;
        else if (v < A_MIN)
            v = A_MIN;
        return v[A_W-1:0];
    endfunction

endpackage

// File: rtl/qr_recon_mac.sv
// Signed multiply-accumulate with clear-on-first-term and scale/saturate output.
// Rounding follows QR_RECON_ROUND_EN through qr_recon_pkg::sat_scale.
module qr_recon_mac
    import qr_recon_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic signed [Q_W-1:0] i_q,
    input  logic signed [R_W-1:0] i_r,
    output logic signed [A_W-1:0] o_a
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod = i_q * i_r;
    assign w_sum  = (i_clr ? '0 : r_acc) + ACC_W'(w_prod);

    // o_a reflects the sum including this cycle's term
    assign o_a = sat_scale(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_sum;
    end

endmodule

// File: rtl/qr_recon.sv
// Rebuilds A = Q * R from a streamed Q-transpose/R pair, one MAC per cycle.
// Build option: QR_RECON_ROUND_EN selects round-half-up scaling.
module qr_recon
    import qr_recon_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic signed [R_W-1:0] in_r,
    input  logic signed [Q_W-1:0] in_q,
    output logic                  out_valid,
    output logic signed [A_W-1:0] out_a,
    output logic                  busy
);

    state_t r_state;
    state_t w_next;

    logic [5:0] r_cnt;
    logic       w_take;
    logic [3:0] w_e;
    logic [1:0] w_k;
    logic [3:0] w_qi;
    logic [3:0] w_ri;
    logic       w_cal;

    logic signed [R_W-1:0] r_rbuf [16];
    logic signed [Q_W-1:0] r_qbuf [16];
    logic signed [A_W-1:0] r_res  [16];

    logic signed [A_W-1:0] w_mac_a;

    logic                  r_pv;
    logic signed [A_W-1:0] r_pa;
    logic                  r_ov;
    logic signed [A_W-1:0] r_oa;

    assign w_take = in_valid &&
                    (r_state == S_IDLE || r_state == S_COLLECT);
    assign w_cal  = (r_state == S_CAL);
    assign w_e    = r_cnt[5:2];
    assign w_k    = r_cnt[1:0];
    // qt[k][i] and r[k][j] with i = e/4, j = e%4
    assign w_qi   = {w_k, w_e[3:2]};
    assign w_ri   = {w_k, w_e[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (in_valid) w_next = S_COLLECT;
            S_COLLECT:
                if (in_valid && r_cnt == 6'd15) w_next = S_CAL;
            S_CAL:
                if (r_cnt == 6'd63) w_next = S_OUTPUT;
            S_OUTPUT:
                if (r_cnt == 6'd15) w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE:
                    r_cnt <= in_valid ? 6'd1 : 6'd0;
                S_COLLECT:
                    if (in_valid)
                        r_cnt <= (r_cnt == 6'd15) ? 6'd0 : r_cnt + 6'd1;
                S_CAL:
                    r_cnt <= (r_cnt == 6'd63) ? 6'd0 : r_cnt + 6'd1;
                S_OUTPUT:
                    r_cnt <= (r_cnt == 6'd15) ? 6'd0 : r_cnt + 6'd1;
                default:
                    r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 16; n++) begin
                r_rbuf[n] <= '0;
                r_qbuf[n] <= '0;
            end
        end else if (w_take) begin
            r_rbuf[r_cnt[3:0]] <= in_r;
            r_qbuf[r_cnt[3:0]] <= in_q;
        end
    end

    qr_recon_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cal),
        .i_clr (w_k == 2'd0),
        .i_q   (r_qbuf[w_qi]),
        .i_r   (r_rbuf[w_ri]),
        .o_a   (w_mac_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 16; n++)
                r_res[n] <= '0;
        end else if (w_cal && w_k == 2'd3) begin
            r_res[w_e] <= w_mac_a;
        end
    end

    // Two register stages: buffer read, then output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= 1'b0;
            r_pa <= '0;
            r_ov <= 1'b0;
            r_oa <= '0;
        end else begin
            r_pv <= (r_state == S_OUTPUT);
            r_pa <= (r_state == S_OUTPUT) ? r_res[r_cnt[3:0]] : '0;
            r_ov <= r_pv;
            r_oa <= r_pv ? r_pa : '0;
        end
    end

    assign out_valid = r_ov;
    assign out_a     = r_oa;
    assign busy      = (r_state == S_CAL) || (r_state == S_OUTPUT);

endmodule

// File: tb/tb_qr_recon.sv
// Directed and random frames for qr_recon, checked against a matrix-product model.
// Expected rounding tracks QR_RECON_ROUND_EN.
module tb_qr_recon;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic signed [11:0] in_r;
    logic signed [11:0] in_q;
    logic              out_valid;
    logic signed [7:0] out_a;
    logic              busy;

    int tests;
    int fails;
    int fq [16];
    int fr [16];
    int ea [16];

    qr_recon dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_a     (out_a),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A = Q*R where fq holds Q-transpose: a[i][j] = sum_k qt[k][i]*r[k][j]
    function automatic void model();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += fq[k*4+i] * fr[k*4+j];
`ifdef QR_RECON_ROUND_EN
                s = s + 4096;
`endif
                s = s >>> 13;
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                ea[i*4+j] = s;
            end
        end
    endfunction

    function automatic void set_ident();
        for (int n = 0; n < 16; n++) begin
            fq[n] = (n % 5 == 0) ? 1024 : 0;
            fr[n] = 0;
        end
    endfunction

    function automatic void set_diag();
        set_ident();
        fr[0]  = 8;
        fr[5]  = 16;
        fr[10] = 24;
        fr[15] = 32;
    endfunction

    function automatic void set_rand();
        for (int n = 0; n < 16; n++) begin
            fq[n] = int'($urandom_range(4095)) - 2048;
            fr[n] = ((n % 4) >= (n / 4)) ? int'($urandom_range(4095)) - 2048 : 0;
        end
    endfunction

    task automatic send(input int gap);
        for (int s = 0; s < 16; s++) begin
            in_valid = 1'b1;
            in_r = 12'(fr[s]);
            in_q = 12'(fq[s]);
            @(posedge clk); #1;
            if (s == 7 && gap > 0) begin
                in_valid = 1'b0;
                in_r = 12'sd1000;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic run_frame(input string tag, input int gap, input bit hold);
        int lat;
        model();
        send(gap);
        if (hold) begin
            in_valid = 1'b1;
            in_r = 12'sd2047;
            in_q = 12'sd1024;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 1);
            if (out_valid) break;
        end
        check({tag, "_latency"}, lat, 66);
        for (int n = 0; n < 16; n++) begin
            if (hold && n == 10) in_valid = 1'b0;
            check({tag, "_valid"}, 32'(out_valid), 1);
            check({tag, $sformatf("_a%0d", n)}, 32'(out_a), ea[n]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_valid_end"}, 32'(out_valid), 0);
        check({tag, "_a_end"}, 32'(out_a), 0);
        check({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        bit seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_r = '0;
        in_q = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_a", 32'(out_a), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_diag();
        run_frame("diag", 0, 1'b0);

        set_ident(); fr[0] = 2047;
        run_frame("sat_hi", 0, 1'b0);
        set_ident(); fr[0] = -2048;
        run_frame("sat_lo", 0, 1'b0);
        set_ident(); fr[0] = 12;
        run_frame("rnd_p12", 0, 1'b0);
        set_ident(); fr[0] = -12;
        run_frame("rnd_m12", 0, 1'b0);

        set_diag();
        run_frame("gap", 3, 1'b0);

        set_rand();
        send(0);
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midcal_busy", 32'(busy), 0);
        check("midcal_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midcal_no_out", 32'(seen), 0);
        set_diag();
        run_frame("after_rst", 0, 1'b0);

        set_diag();
        run_frame("hold", 0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            set_rand();
            run_frame($sformatf("rand%0d", t), t, t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qr_recon.md
QR_RECON -- requirements
Module: qr_recon

Interface
REQ-001 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  qualifies in_r/in_q for one sample of the incoming Q/R result stream.
REQ-004 SHALL have port: in_r  input  12  signed R element, Q8.3, row-major r[i][j], lower-triangle samples carry 0.
REQ-005 SHALL have port: in_q  input  12  signed Q-transpose element qt[i][j], Q1.10 (1.0 = 1024), row-major.
REQ-006 SHALL have port: out_valid  output  1  qualifies out_a.
REQ-007 SHALL have port: out_a  output  8  signed reconstructed A element, integer, row-major.
REQ-008 SHALL have port: busy  output  1  high in CAL and OUTPUT states.

Function
REQ-009 SHALL implement the FSM states IDLE, COLLECT, CAL and OUTPUT.
REQ-010 SHALL accept an in_valid sample in IDLE as element 0 and move to COLLECT; in COLLECT it SHALL write each accepted sample to buffer index cnt.
REQ-011 SHALL hold cnt while in_valid is low inside a frame; gaps of any length SHALL be tolerated.
REQ-012 SHALL enter CAL on the cycle after the 16th accepted sample.
REQ-013 SHALL ignore in_valid in CAL and OUTPUT, with no buffer writes.
REQ-014 SHALL spend exactly 64 cycles in CAL with a single multiply-accumulate per cycle: element e = cnt/4, k = cnt%4, i = e/4, j = e%4.
REQ-015 SHALL compute the CAL term: acc = (k==0 ? 0 : acc) + qt[k][i]*r[k][j], with a 24-bit product and a 26-bit accumulator.
REQ-016 SHALL, at k==3, scale the final sum by >>13, saturate it to [-128,127] and write it to the result buffer[e].
REQ-017 SHALL then run OUTPUT for 16 cycles, driving out_valid=1 and out_a=result[n] through registered outputs for n = 0..15, then return to IDLE.
REQ-018 SHALL raise the first out_valid exactly 66 rising edges after the edge that accepted the 16th sample; out_valid SHALL stay high for 16 consecutive cycles.
REQ-019 SHALL drive out_a=0 whenever out_valid=0.
REQ-020 SHALL accept in_valid on the IDLE cycle that directly follows OUTPUT as a new frame.

Reset
REQ-021 SHALL, on rst_n low at any time, go to IDLE, set cnt=0 and acc=0, set out_valid=0, out_a=0 and busy=0, and clear the input and result buffers.
REQ-022 SHALL, after reset mid-frame or mid-CAL, never emit the partial frame; the next full frame SHALL be processed normally.

Configuration
REQ-023 SHALL use the macro QR_RECON_ROUND_EN to select rounding.
REQ-024 SHALL, with QR_RECON_ROUND_EN defined, add 4096 before the arithmetic >>13, giving round-half-up.
REQ-025 SHALL, without QR_RECON_ROUND_EN, truncate with an arithmetic >>13 (floor); saturation SHALL apply in both builds.

Structure
REQ-026 SHALL place these in shared package qr_recon_pkg: R_W=12, Q_W=12, A_W=8, R_FRAC=3, Q_FRAC=10, PROD_W=24, ACC_W=26, N=4, the FSM state enum and the sat/scale function.
REQ-027 SHALL use one sub-module, qr_recon_mac, which holds the signed multiplier, the accumulator register with clear-on-k0, and the scale/round/saturate stage.

Verification
REQ-028 SHALL cover: QT = identity (diagonal 1024), R diag = 8,16,24,32 -> out_a diag 1,2,3,4 with all other elements 0; out_valid 16 cycles starting at the 66th edge after the last sample.
REQ-029 SHALL cover: QT = identity, r00 = 2047 -> a00 = 127; r00 = -2048 -> a00 = -128.
REQ-030 SHALL cover: QT = identity, r00 = 12 -> a00 = 2 (ROUND_EN) or 1 (no macro); r00 = -12 -> a00 = -1 (ROUND_EN) or -2 (no macro).
REQ-031 SHALL cover: the REQ-028 frame sent with a 3-cycle in_valid gap after sample 7 -> identical out_a sequence, with latency counted from the last sample.
REQ-032 SHALL cover: rst_n pulse at CAL cycle 20 -> out_valid stays 0 and busy drops; a following REQ-028 frame gives the correct result.
REQ-033 SHALL cover: in_valid held high through CAL/OUTPUT with in_r = 2047 -> results unaffected.
